// File: rtl/adiabatic_clkgen_if.sv
// Bundles the run request and all power-clock outputs of adiabatic_clkgen.
interface adiabatic_clkgen_if #(
    parameter int LVL_W = 3,
    parameter int CNT_W = 16
);
    logic             en;
    logic [LVL_W-1:0] pos_lvl;
    logic [LVL_W-1:0] fpos_lvl;
    logic             clkpos;
    logic             clkneg;
    logic             Fclkpos;
    logic             Fclkneg;
    logic [1:0]       phase;
    logic             busy;
    logic             period_done;
    logic [CNT_W-1:0] periods;

    modport master (
        output en,
        input  pos_lvl, fpos_lvl, clkpos, clkneg, Fclkpos, Fclkneg,
        input  phase, busy, period_done, periods
    );

    modport slave (
        input  en,
        output pos_lvl, fpos_lvl, clkpos, clkneg, Fclkpos, Fclkneg,
        output phase, busy, period_done, periods
    );
endinterface

// File: rtl/adiabatic_clkgen.sv
// Trapezoidal four-interval power-clock sequencer: capture phase plus a
// transfer phase lagging by one quarter period, stopping only at period ends.
module adiabatic_clkgen #(
    parameter int LVL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rstneg,
    adiabatic_clkgen_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [LVL_W-1:0] QMAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] periods_q, periods_d;
    logic             active, last_cnt, pdone;

    function automatic logic [LVL_W-1:0] lvl_f(input logic [1:0] p, input logic [LVL_W-1:0] c);
        logic [LVL_W-1:0] l;
        case (p)
            2'd0:    l = c;
            2'd1:    l = QMAX;
            2'd2:    l = QMAX - c;
            default: l = '0;
        endcase
        return l;
    endfunction

    assign active   = (state_q != S_IDLE);
    assign last_cnt = (cnt_q == QMAX);
    assign pdone    = active && (ph_q == 2'd3) && last_cnt;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        periods_d = periods_q;
        if (!active) begin
            if (bus.en) begin
                state_d = S_RUN;
                ph_d    = 2'd0;
                cnt_d   = '0;
            end
        end else begin
            // Q is a power of two, so the natural wrap of cnt is the quarter boundary.
            cnt_d = cnt_q + 1'b1;
            if (last_cnt) ph_d = ph_q + 2'd1;
            if (pdone) periods_d = periods_q + 1'b1;
            if (pdone && !bus.en) state_d = S_IDLE;
            else                  state_d = bus.en ? S_RUN : S_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstneg) begin
            state_q   <= S_IDLE;
            ph_q      <= 2'd0;
            cnt_q     <= '0;
            periods_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            periods_q <= periods_d;
        end
    end

    // Levels decode straight from registered ph/cnt; the transfer phase reuses
    // the same shape one interval behind.
    assign bus.pos_lvl     = active ? lvl_f(ph_q, cnt_q) : '0;
    assign bus.fpos_lvl    = active ? lvl_f(ph_q - 2'd1, cnt_q) : '0;
    assign bus.clkpos      = bus.pos_lvl[LVL_W-1];
    assign bus.clkneg      = ~bus.pos_lvl[LVL_W-1];
    assign bus.Fclkpos     = bus.fpos_lvl[LVL_W-1];
    assign bus.Fclkneg     = ~bus.fpos_lvl[LVL_W-1];
    assign bus.phase       = ph_q;
    assign bus.busy        = active;
    assign bus.period_done = pdone;
    assign bus.periods     = periods_q;
endmodule

// File: tb/tb_adiabatic_clkgen.sv
// Bench for adiabatic_clkgen: reference model feeds a scoreboard queue,
// plus a short table of hand-computed vectors and explicit corner checks.
module tb_adiabatic_clkgen;
    localparam int LVL_W = 3;
    localparam int CNT_W = 16;
    localparam int Q     = 8;
    localparam int P     = 32;

    logic clk = 1'b0;
    logic rstneg;
    always #5 clk = ~clk;

    adiabatic_clkgen_if #(.LVL_W(LVL_W), .CNT_W(CNT_W)) bus();
    adiabatic_clkgen #(.LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rstneg (rstneg),
        .bus    (bus.slave)
    );

    typedef struct {
        int pos;
        int fpos;
        int phase;
        int busy;
        int pd;
        int periods;
    } exp_t;

    typedef struct {
        logic r;
        logic e;
        int   pos;
        int   fpos;
        int   busy;
        int   periods;
    } tv_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit m_busy = 0;
    int m_k = 0;
    int m_periods = 0;

    function automatic int lvl(input int k);
        int q, c;
        q = k / Q;
        c = k % Q;
        case (q)
            0:       return c;
            1:       return Q - 1;
            2:       return Q - 1 - c;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs, advance one edge, update the model, queue and compare.
    task automatic step(input logic r, input logic e, input bit use_tbl, input exp_t te);
        exp_t em, ex;
        rstneg = r;
        bus.en = e;
        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_k = 0; m_periods = 0;
        end else if (!m_busy) begin
            if (e) begin m_busy = 1; m_k = 0; end
        end else begin
            if (m_k == P - 1) begin
                m_periods = (m_periods + 1) % 65536;
                if (!e) m_busy = 0;
            end
            m_k = (m_k + 1) % P;
        end
        em.pos     = m_busy ? lvl(m_k) : 0;
        em.fpos    = m_busy ? lvl((m_k + P - Q) % P) : 0;
        em.phase   = m_busy ? m_k / Q : 0;
        em.busy    = m_busy ? 1 : 0;
        em.pd      = (m_busy && m_k == P - 1) ? 1 : 0;
        em.periods = m_periods;
        sb.push_back(use_tbl ? te : em);
        #1;
        ex = sb.pop_front();
        chk("pos_lvl",     int'(bus.pos_lvl),     ex.pos);
        chk("fpos_lvl",    int'(bus.fpos_lvl),    ex.fpos);
        chk("clkpos",      int'(bus.clkpos),      ex.pos / 4);
        chk("clkneg",      int'(bus.clkneg),      1 - ex.pos / 4);
        chk("Fclkpos",     int'(bus.Fclkpos),     ex.fpos / 4);
        chk("Fclkneg",     int'(bus.Fclkneg),     1 - ex.fpos / 4);
        chk("phase",       int'(bus.phase),       ex.phase);
        chk("busy",        int'(bus.busy),        ex.busy);
        chk("period_done", int'(bus.period_done), ex.pd);
        chk("periods",     int'(bus.periods),     ex.periods);
    endtask

    task automatic run(input logic r, input logic e, input int n);
        exp_t none;
        none = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) step(r, e, 1'b0, none);
    endtask

    tv_t  tv[8];
    exp_t te;
    int   pd_cnt;

    initial begin
        rstneg = 1'b0;
        bus.en = 1'b0;
        // r, e, pos, fpos, busy, periods
        tv[0] = '{1'b0, 1'b0, 0, 0, 0, 0};
        tv[1] = '{1'b1, 1'b1, 0, 0, 1, 0};
        tv[2] = '{1'b1, 1'b1, 1, 0, 1, 0};
        tv[3] = '{1'b1, 1'b1, 2, 0, 1, 0};
        tv[4] = '{1'b1, 1'b0, 3, 0, 1, 0};
        tv[5] = '{1'b1, 1'b1, 4, 0, 1, 0};
        tv[6] = '{1'b0, 1'b1, 0, 0, 0, 0};
        tv[7] = '{1'b1, 1'b0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            te = '{tv[i].pos, tv[i].fpos, 0, tv[i].busy, 0, tv[i].periods};
            step(tv[i].r, tv[i].e, 1'b1, te);
        end

        // Continuous run: three full periods plus a bit, counting pulses.
        pd_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            run(1'b1, 1'b1, 1);
            if (bus.period_done) begin
                pd_cnt++;
                chk("pd_cycle", i, pd_cnt * P - 1);
            end
        end
        chk("pd_count", pd_cnt, 3);

        // Single-cycle en from IDLE: one period, then idle.
        run(1'b0, 1'b0, 1);
        run(1'b1, 1'b1, 1);
        run(1'b1, 1'b0, 40);
        chk("single_busy", int'(bus.busy), 0);
        chk("single_periods", int'(bus.periods), 1);
        chk("single_pos", int'(bus.pos_lvl), 0);

        // en gap mid-run leaves the sequence untouched.
        run(1'b0, 1'b0, 1);
        run(1'b1, 1'b1, 10);
        run(1'b1, 1'b0, 10);
        chk("gap_busy", int'(bus.busy), 1);
        run(1'b1, 1'b1, 20);

        // en dropped mid-period: finishes the period, then idles.
        run(1'b1, 1'b0, 40);
        chk("drain_idle", int'(bus.busy), 0);
        chk("drain_periods", int'(bus.periods), 2);

        // Reset at cycle 14 of the second period.
        run(1'b0, 1'b0, 1);
        run(1'b1, 1'b1, 1 + P + 14);
        chk("pre_rst_pos", int'(bus.pos_lvl), 7);
        chk("pre_rst_fpos", int'(bus.fpos_lvl), 6);
        run(1'b0, 1'b1, 1);
        chk("rst_clkneg", int'(bus.clkneg), 1);
        chk("rst_Fclkneg", int'(bus.Fclkneg), 1);
        chk("rst_periods", int'(bus.periods), 0);
        run(1'b1, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
